clock_divider_monitor: RTL and testbench

- Source-domain observer for a divided clock/reset pair such as the one the clock divider produces.
- Samples the divided clock and reset in the fast source clock domain and emits one-cycle rise and fall clock-enable strobes.
- Measures the half-period of the divided clock, reports lock against the expected divisor, and flags a lost clock or a bad reset sequence.
- Sits beside the divider so that source-domain logic can use clock enables instead of the divided clock as a clock.

---
 rtl/clock_divider_monitor.sv | 197 +++++++++++++++++++
 tb/tb_clock_divider_monitor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_monitor.sv
// Source-domain observer for a divided clock/reset pair: edge clock-enable strobes,
// half-period measurement, lock tracking and reset-sequence fault detection.
module clock_divider_monitor #(
  parameter int unsigned par_clk_divisor = 1000,
  parameter int unsigned par_tolerance   = 2,
  parameter int unsigned par_lock_count  = 4,
  parameter int unsigned par_sync_stages = 2
) (
  input  logic        i_clk_mhz,
  input  logic        i_rst_mhz,
  input  logic        i_clk_div,
  input  logic        i_rst_div,
  output logic        o_rise_ce,
  output logic        o_fall_ce,
  output logic [15:0] o_half_period,
  output logic        o_locked,
  output logic        o_rst_div_done,
  output logic        o_fault
);

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned CNTP_W   = CNT_W + 1;
  localparam int unsigned HALF     = par_clk_divisor / 2;
  localparam int unsigned TOL_HI   = HALF + par_tolerance;
  localparam int unsigned TOL_LO   = (HALF > par_tolerance) ? (HALF - par_tolerance) : 0;
  localparam int unsigned MASK_CYC = par_sync_stages + 1;
  localparam int unsigned MASK_W   = $clog2(MASK_CYC + 1);
  localparam int unsigned GOOD_W   = $clog2(par_lock_count + 1);

  if ((par_clk_divisor == 0) || ((par_clk_divisor % 2) != 0)) begin : g_chk_div
    $error("clock_divider_monitor: par_clk_divisor must be even and non-zero");
  end
  if (TOL_HI >= 65535) begin : g_chk_tol
    $error("clock_divider_monitor: half-period plus tolerance must be below 65535");
  end
  if ((par_sync_stages < 2) || (par_sync_stages > 4)) begin : g_chk_sync
    $error("clock_divider_monitor: par_sync_stages must be 2..4");
  end
  if (par_lock_count == 0) begin : g_chk_lock
    $error("clock_divider_monitor: par_lock_count must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_WAIT_EDGE = 2'd0,
    ST_MEASURE   = 2'd1,
    ST_LOCKED    = 2'd2,
    ST_FAULT     = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [par_sync_stages-1:0] clk_sync_q, clk_sync_d;
  logic [par_sync_stages-1:0] rst_sync_q, rst_sync_d;
  logic                       clk_prev_q, clk_prev_d;
  logic [MASK_W-1:0]          mask_cnt_q, mask_cnt_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [GOOD_W-1:0]          good_q, good_d;
  logic                       rise_seen_q, rise_seen_d;
  logic                       to_seen_q, to_seen_d;
  logic                       rise_ce_q, rise_ce_d;
  logic                       fall_ce_q, fall_ce_d;
  logic [CNT_W-1:0]           half_period_q, half_period_d;
  logic                       locked_q, locked_d;
  logic                       rst_div_done_q, rst_div_done_d;
  logic                       fault_q, fault_d;

  logic              mask_c, clk_s_c, rst_s_c;
  logic              rise_c, fall_c, edge_c;
  logic [CNTP_W-1:0] cnt_p1_c;
  logic              in_tol_c, over_c, timeout_c, ref_c;

  // Synchronizers, masked edge detection and the strobe-to-strobe counter.
  always_comb begin
    clk_sync_d  = {clk_sync_q[par_sync_stages-2:0], i_clk_div};
    rst_sync_d  = {rst_sync_q[par_sync_stages-2:0], i_rst_div};
    clk_s_c     = clk_sync_q[par_sync_stages-1];
    rst_s_c     = rst_sync_q[par_sync_stages-1];
    clk_prev_d  = clk_s_c;
    mask_c      = (mask_cnt_q != MASK_W'(MASK_CYC));
    mask_cnt_d  = mask_c ? (mask_cnt_q + MASK_W'(1)) : mask_cnt_q;
    rise_c      = clk_s_c & ~clk_prev_q & ~mask_c;
    fall_c      = ~clk_s_c & clk_prev_q & ~mask_c;
    edge_c      = rise_c | fall_c;
    cnt_p1_c    = CNTP_W'(cnt_q) + CNTP_W'(1);
    in_tol_c    = (cnt_p1_c >= CNTP_W'(TOL_LO)) && (cnt_p1_c <= CNTP_W'(TOL_HI));
    over_c      = (cnt_p1_c > CNTP_W'(TOL_HI));
    // A timeout fires once per gap; an edge in the same cycle takes priority.
    timeout_c   = ~edge_c & over_c & ~to_seen_q;
    to_seen_d   = ~edge_c & (to_seen_q | over_c);
    ref_c       = (state_q == ST_MEASURE) || (state_q == ST_LOCKED);
    rise_seen_d = rise_seen_q | rise_c;
    cnt_d       = edge_c ? '0 : ((&cnt_q) ? cnt_q : (cnt_q + CNT_W'(1)));
  end

  always_ff @(posedge i_clk_mhz) begin
    if (i_rst_mhz) begin
      state_q <= ST_WAIT_EDGE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and good-count update.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      ST_WAIT_EDGE: begin
        if (edge_c) begin
          state_d = ST_MEASURE;
          good_d  = '0;
        end
      end
      ST_MEASURE: begin
        if (edge_c && in_tol_c) begin
          good_d = good_q + GOOD_W'(1);
          if (good_d == GOOD_W'(par_lock_count)) begin
            state_d = ST_LOCKED;
          end
        end else if (edge_c || timeout_c) begin
          good_d = '0;
        end
      end
      ST_LOCKED: begin
        if ((edge_c && !in_tol_c) || timeout_c) begin
          state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (edge_c) begin
          state_d = ST_MEASURE;
          good_d  = '0;
        end
      end
      default: begin
        state_d = ST_WAIT_EDGE;
        good_d  = '0;
      end
    endcase
  end

  // Registered outputs; the half-period load rides in the same update as the strobe.
  always_comb begin
    rise_ce_d     = rise_c;
    fall_ce_d     = fall_c;
    half_period_d = half_period_q;
    if (edge_c && ref_c) begin
      half_period_d = cnt_p1_c[CNTP_W-1] ? '1 : cnt_p1_c[CNT_W-1:0];
    end
    locked_d       = (state_d == ST_LOCKED);
    rst_div_done_d = rst_div_done_q | (~rst_s_c & rise_seen_q);
    fault_d        = fault_q
                   | ((state_q == ST_LOCKED) && (state_d == ST_FAULT))
                   | (~rst_s_c & ~rise_seen_q);
  end

  always_ff @(posedge i_clk_mhz) begin
    if (i_rst_mhz) begin
      clk_sync_q     <= '0;
      rst_sync_q     <= '1;
      clk_prev_q     <= 1'b0;
      mask_cnt_q     <= '0;
      cnt_q          <= '0;
      good_q         <= '0;
      rise_seen_q    <= 1'b0;
      to_seen_q      <= 1'b0;
      rise_ce_q      <= 1'b0;
      fall_ce_q      <= 1'b0;
      half_period_q  <= '0;
      locked_q       <= 1'b0;
      rst_div_done_q <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      clk_sync_q     <= clk_sync_d;
      rst_sync_q     <= rst_sync_d;
      clk_prev_q     <= clk_prev_d;
      mask_cnt_q     <= mask_cnt_d;
      cnt_q          <= cnt_d;
      good_q         <= good_d;
      rise_seen_q    <= rise_seen_d;
      to_seen_q      <= to_seen_d;
      rise_ce_q      <= rise_ce_d;
      fall_ce_q      <= fall_ce_d;
      half_period_q  <= half_period_d;
      locked_q       <= locked_d;
      rst_div_done_q <= rst_div_done_d;
      fault_q        <= fault_d;
    end
  end

  assign o_rise_ce      = rise_ce_q;
  assign o_fall_ce      = fall_ce_q;
  assign o_half_period  = half_period_q;
  assign o_locked       = locked_q;
  assign o_rst_div_done = rst_div_done_q;
  assign o_fault        = fault_q;

endmodule

// File: tb/tb_clock_divider_monitor.sv
// Directed bench for clock_divider_monitor: divisor 8, tolerance 1, lock after 4, 2-stage sync.
module tb_clock_divider_monitor;

  logic        clk_mhz = 1'b0;
  logic        rst_mhz = 1'b1;
  logic        clk_div = 1'b0;
  logic        rst_div = 1'b1;
  logic        rise_ce, fall_ce, locked, rst_div_done, fault;
  logic [15:0] half_period;

  int n_checks = 0;
  int n_fail   = 0;

  clock_divider_monitor #(
    .par_clk_divisor(8),
    .par_tolerance  (1),
    .par_lock_count (4),
    .par_sync_stages(2)
  ) dut (
    .i_clk_mhz     (clk_mhz),
    .i_rst_mhz     (rst_mhz),
    .i_clk_div     (clk_div),
    .i_rst_div     (rst_div),
    .o_rise_ce     (rise_ce),
    .o_fall_ce     (fall_ce),
    .o_half_period (half_period),
    .o_locked      (locked),
    .o_rst_div_done(rst_div_done),
    .o_fault       (fault)
  );

  always #5 clk_mhz = ~clk_mhz;

  // One record = a divided-clock level held for len cycles; outputs checked
  // 3 cycles after the level is applied, where its strobe must appear.
  typedef struct {
    logic        clk_div;
    logic        rst_div;
    int          len;
    logic        rise;
    logic        fall;
    logic [15:0] half;
    logic        locked;
    logic        done;
    logic        fault;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int c, input int rd, input int len, input int r, input int f,
                     input int h, input int l, input int d, input int x);
    vec_t v;
    v.clk_div = 1'(c);
    v.rst_div = 1'(rd);
    v.len     = len;
    v.rise    = 1'(r);
    v.fall    = 1'(f);
    v.half    = 16'(h);
    v.locked  = 1'(l);
    v.done    = 1'(d);
    v.fault   = 1'(x);
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk_mhz);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic r, input logic f, input logic [15:0] h,
                           input logic l, input logic d, input logic x);
    chk({tag, " rise_ce"},      16'(rise_ce),      16'(r));
    chk({tag, " fall_ce"},      16'(fall_ce),      16'(f));
    chk({tag, " half_period"},  half_period,       h);
    chk({tag, " locked"},       16'(locked),       16'(l));
    chk({tag, " rst_div_done"}, 16'(rst_div_done), 16'(d));
    chk({tag, " fault"},        16'(fault),        16'(x));
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      clk_div = tbl[i].clk_div;
      rst_div = tbl[i].rst_div;
      repeat (3) tick();
      check_all($sformatf("vec%0d", i), tbl[i].rise, tbl[i].fall, tbl[i].half,
                tbl[i].locked, tbl[i].done, tbl[i].fault);
      repeat (tbl[i].len - 3) tick();
    end
  endtask

  initial begin
    // A 0-8: acquire lock, then one 5-cycle half-period while locked
    add(0, 1, 6, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4, 1, 0, 0, 0, 0, 0);
    add(0, 0, 4, 0, 1, 4, 0, 1, 0);
    add(1, 0, 4, 1, 0, 4, 0, 1, 0);
    add(0, 0, 4, 0, 1, 4, 0, 1, 0);
    add(1, 0, 4, 1, 0, 4, 1, 1, 0);
    add(0, 0, 5, 0, 1, 4, 1, 1, 0);
    add(1, 0, 4, 1, 0, 5, 1, 1, 0);
    add(0, 0, 4, 0, 1, 4, 1, 1, 0);
    // B 9-13: relock after a timeout fault, fault stays sticky
    add(1, 0, 4, 1, 0, 4, 0, 1, 1);
    add(0, 0, 4, 0, 1, 4, 0, 1, 1);
    add(1, 0, 4, 1, 0, 4, 0, 1, 1);
    add(0, 0, 4, 0, 1, 4, 0, 1, 1);
    add(1, 0, 4, 1, 0, 4, 1, 1, 1);
    // C 14-21: 6-cycle half-periods never lock, then 4-cycle ones do
    add(0, 1, 6, 0, 1, 0, 0, 0, 0);
    add(1, 1, 6, 1, 0, 6, 0, 0, 0);
    add(0, 0, 6, 0, 1, 6, 0, 1, 0);
    add(1, 0, 4, 1, 0, 6, 0, 1, 0);
    add(0, 0, 4, 0, 1, 4, 0, 1, 0);
    add(1, 0, 4, 1, 0, 4, 0, 1, 0);
    add(0, 0, 4, 0, 1, 4, 0, 1, 0);
    add(1, 0, 4, 1, 0, 4, 1, 1, 0);
    // D 22-23: first rise after an early divided-reset release
    add(1, 0, 4, 1, 0, 0, 0, 0, 1);
    add(0, 0, 4, 0, 1, 4, 0, 1, 1);

    rst_mhz = 1'b1;
    clk_div = 1'b0;
    rst_div = 1'b1;
    repeat (2) tick();
    check_all("reset", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    rst_mhz = 1'b0;
    run_range(0, 8);

    // Freeze the divided clock while locked: fault lands when cnt+1 reaches 6.
    repeat (4) tick();
    chk("freeze cnt+1=5 fault", 16'(fault), 16'd0);
    chk("freeze cnt+1=5 locked", 16'(locked), 16'd1);
    tick();
    chk("freeze cnt+1=6 fault", 16'(fault), 16'd1);
    chk("freeze cnt+1=6 locked", 16'(locked), 16'd0);
    repeat (5) tick();
    chk("freeze half_period held", half_period, 16'd4);
    run_range(9, 13);

    // One-cycle source reset while locked, divided clock held high through release.
    rst_mhz = 1'b1;
    rst_div = 1'b1;
    tick();
    check_all("midreset", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    rst_mhz = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("post-release c%0d rise_ce", k + 1), 16'(rise_ce), 16'd0);
      chk($sformatf("post-release c%0d fall_ce", k + 1), 16'(fall_ce), 16'd0);
    end
    run_range(14, 21);

    // Divided reset released before any divided-clock rise.
    rst_mhz = 1'b1;
    clk_div = 1'b0;
    rst_div = 1'b1;
    tick();
    check_all("reset2", 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    rst_mhz = 1'b0;
    repeat (4) tick();
    rst_div = 1'b0;
    repeat (2) tick();
    chk("early rst_div c2 fault", 16'(fault), 16'd0);
    tick();
    chk("early rst_div c3 fault", 16'(fault), 16'd1);
    chk("early rst_div c3 done", 16'(rst_div_done), 16'd0);
    run_range(22, 23);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
